// File: rtl/ph_track_comp.sv
// Phase-tracking compensator: buffers one OFDM symbol of data subcarriers, waits for the
// symbol's phase estimate, then streams every sample multiplied by the conjugate of that phase.
module ph_track_comp #(
  parameter int N_DAT  = 192,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] datin_Re,
  input  logic signed [15:0] datin_Im,
  input  logic               datin_val,
  input  logic signed [15:0] ph_Re,
  input  logic signed [15:0] ph_Im,
  input  logic               ph_val,
  output logic signed [15:0] datout_Re,
  output logic signed [15:0] datout_Im,
  output logic               datout_val,
  output logic               datout_last,
  output logic               busy,
  output logic               err
);

  // One extra counter bit so a full 2**ADDR_W symbol can still be counted.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DAT - 1);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_PH, DRAIN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   wr_cnt;
  logic [CNT_W-1:0]   rd_cnt;
  logic signed [15:0] ph_hold_re;
  logic signed [15:0] ph_hold_im;
  logic               ph_have;

  logic [31:0]        mem [2**ADDR_W];
  logic [31:0]        rd_q;
  logic               wr_en;
  logic               rd_en;

  logic               val1;
  logic               last1;
  logic               val2;
  logic               last2;
  logic signed [15:0] x_re;
  logic signed [15:0] x_im;
  logic signed [31:0] p_ac;
  logic signed [31:0] p_bd;
  logic signed [31:0] p_bc;
  logic signed [31:0] p_ad;
  logic signed [32:0] sum_re;
  logic signed [32:0] sum_im;
  logic signed [15:0] sat_re;
  logic signed [15:0] sat_im;

  assign wr_en = (state == FILL) && datin_val && !start;
  assign rd_en = (state == DRAIN) && !start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      err        <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      ph_hold_re <= '0;
      ph_hold_im <= '0;
      ph_have    <= 1'b0;
    end else if (start) begin
      // A phase arriving together with start belongs to the new symbol.
      state   <= FILL;
      busy    <= 1'b1;
      err     <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      ph_have <= ph_val;
      if (ph_val) begin
        ph_hold_re <= ph_Re;
        ph_hold_im <= ph_Im;
      end
    end else begin
      if (ph_val) begin
        if (state == FILL || state == WAIT_PH) begin
          ph_hold_re <= ph_Re;
          ph_hold_im <= ph_Im;
          ph_have    <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (datin_val) err <= 1'b1;
        end
        FILL: begin
          if (datin_val) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LAST) begin
              rd_cnt <= '0;
              state  <= (ph_have || ph_val) ? DRAIN : WAIT_PH;
            end
          end
        end
        WAIT_PH: begin
          if (datin_val) err <= 1'b1;
          if (ph_val) begin
            rd_cnt <= '0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (datin_val) err <= 1'b1;
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Symbol buffer is never reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt[ADDR_W-1:0]] <= {datin_Re, datin_Im};
    if (rd_en) rd_q <= mem[rd_cnt[ADDR_W-1:0]];
  end

  assign x_re = $signed(rd_q[31:16]);
  assign x_im = $signed(rd_q[15:0]);

  assign sum_re = {p_ac[31], p_ac} + {p_bd[31], p_bd};
  assign sum_im = {p_bc[31], p_bc} - {p_ad[31], p_ad};

  function automatic logic signed [15:0] round_sat(input logic signed [32:0] s);
    logic signed [32:0] r;
    r = (s + 33'sd4096) >>> 13;
    if (r > 33'sd32767)       return 16'sh7FFF;
    else if (r < -33'sd32768) return 16'sh8000;
    else                      return r[15:0];
  endfunction

  assign sat_re = round_sat(sum_re);
  assign sat_im = round_sat(sum_im);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val1        <= 1'b0;
      last1       <= 1'b0;
      val2        <= 1'b0;
      last2       <= 1'b0;
      p_ac        <= '0;
      p_bd        <= '0;
      p_bc        <= '0;
      p_ad        <= '0;
      datout_Re   <= '0;
      datout_Im   <= '0;
      datout_val  <= 1'b0;
      datout_last <= 1'b0;
    end else begin
      val1  <= rd_en;
      last1 <= rd_en && (rd_cnt == LAST);
      val2  <= val1 && !start;
      last2 <= last1;
      p_ac  <= x_re * ph_hold_re;
      p_bd  <= x_im * ph_hold_im;
      p_bc  <= x_im * ph_hold_re;
      p_ad  <= x_re * ph_hold_im;
      datout_val  <= val2 && !start;
      datout_last <= val2 && last2 && !start;
      if (val2 && !start) begin
        datout_Re <= sat_re;
        datout_Im <= sat_im;
      end
    end
  end

endmodule
